data_mem_responder: RTL and testbench

//   Data-memory responder on the far side of the core's CEN/WEN/OEN/A/Data2Mem/ReadDataMem port.

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: same-cycle loads, stores absorbed by a store buffer that drains into a
// slow multi-cycle-write word array. Optional in-place store coalescing under DMEM_SB_COALESCE_EN.
module data_mem_responder #(
    parameter int AW        = 7,
    parameter int SB_DEPTH  = 4,
    parameter int WR_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      CEN,
    input  logic                      WEN,
    input  logic                      OEN,
    input  logic [AW-1:0]             A,
    input  logic [31:0]               Data2Mem,
    output logic [31:0]               ReadDataMem,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty,
    output logic                      overflow
);

    localparam int PW    = $clog2(SB_DEPTH);
    localparam int CW    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int WORDS = 1 << AW;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [PW-1:0]  head_reg, tail_reg;
    logic [PW:0]    count_reg;
    logic           overflow_reg;

    logic [31:0]    mem [WORDS];
    logic [AW-1:0]  sb_addr [SB_DEPTH];
    logic [31:0]    sb_data [SB_DEPTH];

    logic           load, store;
    logic           full, pop, push, drop;
    logic [SB_DEPTH-1:0] slot_valid, match;
    logic           fwd_hit;
    logic [31:0]    fwd_data;
    logic           coal_hit;
    logic [PW-1:0]  coal_idx;

    assign load  = !CEN && !OEN &&  WEN;
    assign store = !CEN && !WEN &&  OEN;
    assign full  = (count_reg == (PW+1)'(SB_DEPTH));

    // A slot is valid when its age relative to the head is below the live count.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
            logic [PW-1:0] age;
            assign age            = PW'(gi) - head_reg;
            assign slot_valid[gi] = ({1'b0, age} < count_reg);
            assign match[gi]      = slot_valid[gi] && (sb_addr[gi] == A);
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (match[head_reg + PW'(k)]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head_reg + PW'(k)];
            end
        end
    end

    always_comb begin
        coal_hit = 1'b0;
        coal_idx = head_reg;
`ifdef DMEM_SB_COALESCE_EN
        // The head being written out is frozen; a store hitting only that entry allocates anew.
        if (store) begin
            for (int k = 0; k < SB_DEPTH; k++) begin
                if (match[head_reg + PW'(k)] && !(k == 0 && state_reg == WRITE)) begin
                    coal_hit = 1'b1;
                    coal_idx = head_reg + PW'(k);
                end
            end
        end
`endif
    end

    assign ReadDataMem = load ? (fwd_hit ? fwd_data : mem[A]) : '0;

    // Drain FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    state_next = WRITE;
                    cnt_next   = CW'(WR_CYCLES - 1);
                end
            end
            WRITE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (count_reg > (PW+1)'(1) || push) begin
                    cnt_next = CW'(WR_CYCLES - 1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM: outputs and buffer handshakes
    always_comb begin
        pop      = (state_reg == WRITE) && (cnt_reg == '0);
        push     = store && !coal_hit && (!full || pop);
        drop     = store && !coal_hit && full && !pop;
        sb_empty = (count_reg == '0) && (state_reg == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // Buffer payload needs no reset: validity comes entirely from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail_reg] <= A;
            sb_data[tail_reg] <= Data2Mem;
        end else if (coal_hit) begin
            sb_data[coal_idx] <= Data2Mem;
        end
    end

    // The head slot cannot change while it is being written out, so the commit reads it directly
    // instead of keeping a separate latched copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (pop) begin
            mem[sb_addr[head_reg]] <= sb_data[head_reg];
        end
    end

    assign sb_count = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic checked against a
// timing-level reference model (each store is scheduled for a commit edge when it is accepted).
module tb_data_mem_responder;

    localparam int AW    = 7;
    localparam int DEPTH = 4;
    localparam int WR    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [31:0] Data2Mem;
    logic [31:0] ReadDataMem;
    logic [$clog2(DEPTH):0] sb_count;
    logic        sb_empty;
    logic        overflow;

    data_mem_responder #(.AW(AW), .SB_DEPTH(DEPTH), .WR_CYCLES(WR)) dut (
        .clk(clk), .rst(rst), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
        .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .sb_count(sb_count),
        .sb_empty(sb_empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            commit;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [0:(1<<AW)-1];
    bit          ovf_m;
    int          last_commit;
    int          edge_no = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_seen, rd_exp;
    bit          last_dropped;

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].addr == a) return q[i].data;
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        q.delete();
        ovf_m       = 1'b0;
        last_commit = -100;
    endtask

    // One clock of stimulus; the model advances at the same edge.
    task automatic cycle(input logic cen, input logic wen, input logic oen,
                         input logic [AW-1:0] a, input logic [31:0] d);
        bit is_load, is_store, pop_m, coal, accept;
        string opname;
        CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d;
        is_load  = !cen && !oen && wen;
        is_store = !cen && !wen && oen;
        opname   = is_load ? "LD" : (is_store ? "ST" : "NOP");
        #2;
        rd_seen = ReadDataMem;
        rd_exp  = is_load ? model_read(a) : 32'h0;
        @(posedge clk);
        edge_no++;
        pop_m  = (q.size() > 0) && (q[0].commit == edge_no);
        coal   = 1'b0;
        accept = 1'b0;
        last_dropped = 1'b0;
        if (is_store) begin
`ifdef DMEM_SB_COALESCE_EN
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (i == 0 && edge_no > q[0].commit - WR) continue;
                if (q[i].addr == a) begin
                    q[i].data = d;
                    coal = 1'b1;
                    break;
                end
            end
`endif
            if (!coal) begin
                if (q.size() < DEPTH || pop_m) accept = 1'b1;
                else begin
                    last_dropped = 1'b1;
                    ovf_m = 1'b1;
                end
            end
        end
        if (pop_m) begin
            mem_m[q[0].addr] = q[0].data;
            void'(q.pop_front());
        end
        if (accept) begin
            ent_t e;
            e.addr   = a;
            e.data   = d;
            e.commit = ((edge_no > last_commit) ? edge_no + 1 : last_commit) + WR;
            last_commit = e.commit;
            q.push_back(e);
        end
        #1;
        $display("e%0d %s A=%02h D=%08h rd=%08h cnt=%0d empty=%0b ovf=%0b",
                 edge_no, opname, a, d, rd_seen, sb_count, sb_empty, overflow);
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_load(input logic [AW-1:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, '0, 32'h0);
    endtask

    task automatic apply_reset();
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h10; Data2Mem = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sb_count !== 0) begin errors++; $display("FAIL rst_count: got %0d want 0", sb_count); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", sb_empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL rst_rd: got %08h want 0", ReadDataMem); end
        rst = 1'b0;
        model_reset();
        // Asynchronous reset in the middle of a drain with three entries queued.
        do_store(7'd20, 32'hA0A0_0020);
        do_store(7'd21, 32'hA0A0_0021);
        do_store(7'd22, 32'hA0A0_0022);
        checks++; if (sb_count !== 3) begin errors++; $display("FAIL middrain_count: got %0d want 3", sb_count); end
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'd20;
        #1 rst = 1'b1;
        #1;
        checks++; if (sb_count !== 0) begin errors++; $display("FAIL arst_count: got %0d want 0", sb_count); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %0b want 1", sb_empty); end
        checks++; if (ReadDataMem !== 32'h0) begin errors++; $display("FAIL arst_rd: got %08h want 0", ReadDataMem); end
        #1 rst = 1'b0;
        model_reset();
        do_idle(2 * WR + 2);
        do_load(7'd20);
        checks++; if (rd_seen !== 32'h0) begin errors++; $display("FAIL aborted_word: got %08h want 0", rd_seen); end
    endtask

    task automatic test_forward();
        apply_reset();
        do_store(7'd5, 32'hDEAD_BEEF);
        do_load(7'd5);
        checks++; if (rd_seen !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_rd: got %08h want deadbeef", rd_seen); end
        do_idle(WR - 1);
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL pre_commit_empty: got %0b want 0", sb_empty); end
        do_idle(1);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL post_commit_empty: got %0b want 1", sb_empty); end
        checks++; if (sb_count !== 0) begin errors++; $display("FAIL post_commit_count: got %0d want 0", sb_count); end
        do_load(7'd5);
        checks++; if (rd_seen !== 32'hDEAD_BEEF) begin errors++; $display("FAIL array_rd: got %08h want deadbeef", rd_seen); end
    endtask

    task automatic test_same_addr();
        int exp_cnt;
`ifdef DMEM_SB_COALESCE_EN
        exp_cnt = 1;
`else
        exp_cnt = 2;
`endif
        apply_reset();
        do_store(7'd9, 32'h11);
        do_store(7'd9, 32'h22);
        checks++; if (sb_count !== exp_cnt) begin errors++; $display("FAIL same_addr_count: got %0d want %0d", sb_count, exp_cnt); end
        do_load(7'd9);
        checks++; if (rd_seen !== 32'h22) begin errors++; $display("FAIL youngest_rd: got %08h want 22", rd_seen); end
        do_idle(3 * WR);
        do_load(7'd9);
        checks++; if (rd_seen !== 32'h22) begin errors++; $display("FAIL same_addr_array: got %08h want 22", rd_seen); end
    endtask

    task automatic test_overflow();
        logic [31:0] dat [6];
        bit drop_exp [6];
        bit ovf_exp;
        apply_reset();
        ovf_exp = 1'b0;
        // Store k lands on edge k; the first commit frees a slot on edge WR+1.
        for (int k = 0; k < 6; k++) begin
            int cnt_exp;
            dat[k] = $urandom;
            drop_exp[k] = (k >= DEPTH) && (k < WR + 1);
            ovf_exp = ovf_exp | drop_exp[k];
            cnt_exp = (k + 1 < DEPTH) ? k + 1 : DEPTH;
            do_store(AW'(40 + k), dat[k]);
            checks++; if (sb_count !== cnt_exp) begin errors++; $display("FAIL ovf_count%0d: got %0d want %0d", k, sb_count, cnt_exp); end
            checks++; if (overflow !== ovf_exp) begin errors++; $display("FAIL ovf_flag%0d: got %0b want %0b", k, overflow, ovf_exp); end
        end
        do_idle(WR * (DEPTH + 1) + 2);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %0b want 1", sb_empty); end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] want;
            want = drop_exp[k] ? 32'h0 : dat[k];
            do_load(AW'(40 + k));
            checks++; if (rd_seen !== want) begin errors++; $display("FAIL ovf_read%0d: got %08h want %08h", k, rd_seen, want); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_top_addr();
        logic [31:0] d;
        apply_reset();
        d = $urandom | 32'h1;
        do_store(7'h7F, d);
        do_idle(WR + 1);
        do_load(7'h7F);
        checks++; if (rd_seen !== d) begin errors++; $display("FAIL top_rd: got %08h want %08h", rd_seen, d); end
        do_load(7'h00);
        checks++; if (rd_seen !== 32'h0) begin errors++; $display("FAIL alias_rd: got %08h want 0", rd_seen); end
    endtask

    task automatic test_noop();
        apply_reset();
        do_store(7'd3, 32'h3333_3333);
        cycle(1'b0, 1'b0, 1'b0, 7'd3, 32'hFFFF_FFFF);
        checks++; if (rd_seen !== 32'h0) begin errors++; $display("FAIL noop_both_rd: got %08h want 0", rd_seen); end
        checks++; if (sb_count !== 1) begin errors++; $display("FAIL noop_both_count: got %0d want 1", sb_count); end
        cycle(1'b0, 1'b1, 1'b1, 7'd3, 32'hFFFF_FFFF);
        checks++; if (rd_seen !== 32'h0) begin errors++; $display("FAIL noop_none_rd: got %08h want 0", rd_seen); end
        cycle(1'b1, 1'b1, 1'b0, 7'd3, 32'h0);
        checks++; if (rd_seen !== 32'h0) begin errors++; $display("FAIL noop_cen_rd: got %08h want 0", rd_seen); end
        checks++; if (sb_count !== 1) begin errors++; $display("FAIL noop_cen_count: got %0d want 1", sb_count); end
        do_idle(WR + 2);
        do_load(7'd3);
        checks++; if (rd_seen !== 32'h3333_3333) begin errors++; $display("FAIL noop_array: got %08h want 33333333", rd_seen); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [AW-1:0] a;
            if (n % 100 == 99) do_idle(25);
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, (1 << AW) - 1))
                                            : AW'($urandom_range(0, 7));
            if (r < 4)      do_store(a, $urandom);
            else if (r < 8) do_load(a);
            else if (r < 9) begin
                logic b;
                b = 1'($urandom_range(0, 1));
                cycle(1'b0, b, b, a, $urandom);
            end else cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            checks++; if (rd_seen !== rd_exp) begin errors++; $display("FAIL rnd_rd e%0d: got %08h want %08h", edge_no, rd_seen, rd_exp); end
            checks++; if (sb_count !== q.size()) begin errors++; $display("FAIL rnd_count e%0d: got %0d want %0d", edge_no, sb_count, q.size()); end
            checks++; if (sb_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty e%0d: got %0b want %0b", edge_no, sb_empty, q.size() == 0); end
            checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL rnd_ovf e%0d: got %0b want %0b", edge_no, overflow, ovf_m); end
        end
        do_idle(WR * (DEPTH + 1) + 2);
        for (int i = 0; i < (1 << AW); i++) begin
            do_load(AW'(i));
            checks++; if (rd_seen !== rd_exp) begin errors++; $display("FAIL sweep_rd %02h: got %08h want %08h", i, rd_seen, rd_exp); end
        end
    endtask

    initial begin
        rst = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
        model_reset();
        test_reset();
        test_forward();
        test_same_addr();
        test_overflow();
        test_top_addr();
        test_noop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
